// File: rtl/cnt_mod_prescaled.sv
// cnt_mod_prescaled: prescaled modulo-MODULUS up/down counter with registered tick/carry pulses.
// Latency: one in_clk edge from inputs to q/tick/carry; tick and carry coincide with the new q.
// Backpressure: none; en gates progress, and rst and load take precedence over en.
//
// Ports:
//   in_clk    clock; all state changes on its rising edge
//   rst       synchronous active-high reset (ps, q, tick, carry cleared)
//   en        count enable; prescaler and counter hold while low
//   up_dn     direction, 1 = up, 0 = down; only the value at the step edge matters
//   load      synchronous load of load_val (clamped to MODULUS-1); no pulse is produced
//   load_val  value written on load
//   q         current count, always within 0..MODULUS-1
//   tick      one-cycle pulse on every counter step
//   carry     one-cycle pulse on wrap (up MODULUS-1 -> 0, down 0 -> MODULUS-1)
// Optional build macro CNT_MOD_BCD_EN adds registered bcd_tens/bcd_ones that track q.
module cnt_mod_prescaled #(
  parameter int PRESCALE = 600,
  parameter int PS_WIDTH = 10,
  parameter int MODULUS  = 60,
  parameter int WIDTH    = 7
) (
  input  logic             in_clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             carry
`ifdef CNT_MOD_BCD_EN
  ,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
`endif
);

  localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(PRESCALE - 1);
  localparam logic [WIDTH-1:0]    Q_MAX   = WIDTH'(MODULUS - 1);

  logic [PS_WIDTH-1:0] ps;
  logic                step;
  logic                wrap;
  logic [WIDTH-1:0]    load_clamped;

  // With PRESCALE=1 PS_LAST is 0, so ps never moves and every enabled cycle is a step.
  assign step         = en && (ps == PS_LAST);
  assign wrap         = up_dn ? (q == Q_MAX) : (q == '0);
  assign load_clamped = (load_val > Q_MAX) ? Q_MAX : load_val;

  always_ff @(posedge in_clk) begin
    if (rst) begin
      ps    <= '0;
      q     <= '0;
      tick  <= 1'b0;
      carry <= 1'b0;
    end else if (load) begin
      ps    <= '0;
      q     <= load_clamped;
      tick  <= 1'b0;
      carry <= 1'b0;
    end else begin
      tick  <= step;
      carry <= step && wrap;
      if (en) begin
        ps <= step ? '0 : ps + PS_WIDTH'(1);
      end
      if (step) begin
        if (wrap) begin
          q <= up_dn ? '0 : Q_MAX;
        end else begin
          q <= up_dn ? q + WIDTH'(1) : q - WIDTH'(1);
        end
      end
    end
  end

`ifdef CNT_MOD_BCD_EN
  localparam logic [3:0] MAX_TENS = 4'((MODULUS - 1) / 10);
  localparam logic [3:0] MAX_ONES = 4'((MODULUS - 1) % 10);

  // Binary-to-BCD for the load path only: a repeated-subtract ladder, at most nine
  // stages since q never exceeds 99. Steps use the digit counters below instead.
  function automatic logic [7:0] to_bcd(input logic [WIDTH-1:0] v);
    int         r;
    logic [3:0] t;
    r = int'(v);
    t = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (r >= 10) begin
        r = r - 10;
        t = t + 4'd1;
      end
    end
    return {t, 4'(r)};
  endfunction

  logic [7:0] load_bcd;
  assign load_bcd = to_bcd(load_clamped);

  always_ff @(posedge in_clk) begin
    if (rst) begin
      bcd_tens <= 4'd0;
      bcd_ones <= 4'd0;
    end else if (load) begin
      bcd_tens <= load_bcd[7:4];
      bcd_ones <= load_bcd[3:0];
    end else if (step) begin
      if (up_dn) begin
        if (wrap) begin
          bcd_tens <= 4'd0;
          bcd_ones <= 4'd0;
        end else if (bcd_ones == 4'd9) begin
          bcd_tens <= bcd_tens + 4'd1;
          bcd_ones <= 4'd0;
        end else begin
          bcd_ones <= bcd_ones + 4'd1;
        end
      end else begin
        if (wrap) begin
          bcd_tens <= MAX_TENS;
          bcd_ones <= MAX_ONES;
        end else if (bcd_ones == 4'd0) begin
          bcd_tens <= bcd_tens - 4'd1;
          bcd_ones <= 4'd9;
        end else begin
          bcd_ones <= bcd_ones - 4'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cnt_mod_prescaled.sv
// tb_cnt_mod_prescaled: exercises a small counter (PRESCALE=4, MODULUS=10), a MODULUS=60
// counter for load/BCD tracking, and a default-parameter seconds->minutes cascade.
// Inputs change just after the falling edge; outputs are read around the falling edge.
module tb_cnt_mod_prescaled;

  logic in_clk;
  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  int n_chk;
  int n_fail;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge in_clk);
    #1;
  endtask

  // ---------------- small instance: PRESCALE=4, MODULUS=10 ----------------
  localparam int SP = 4;
  localparam int SM = 10;
  logic       s_rst, s_en, s_up, s_load;
  logic [3:0] s_lv, s_q;
  logic       s_tick, s_carry;
`ifdef CNT_MOD_BCD_EN
  logic [3:0] s_bt, s_bo;
`endif

  cnt_mod_prescaled #(.PRESCALE(SP), .PS_WIDTH(2), .MODULUS(SM), .WIDTH(4)) u_small (
    .in_clk(in_clk), .rst(s_rst), .en(s_en), .up_dn(s_up), .load(s_load),
    .load_val(s_lv), .q(s_q), .tick(s_tick), .carry(s_carry)
`ifdef CNT_MOD_BCD_EN
    , .bcd_tens(s_bt), .bcd_ones(s_bo)
`endif
  );

  // ---------------- MODULUS=60 instance for load/BCD ----------------
  logic       g_rst, g_en, g_up, g_load;
  logic [6:0] g_lv, g_q;
  logic       g_tick, g_carry;
`ifdef CNT_MOD_BCD_EN
  logic [3:0] g_bt, g_bo;
`endif

  cnt_mod_prescaled #(.PRESCALE(3), .PS_WIDTH(2), .MODULUS(60), .WIDTH(7)) u_m60 (
    .in_clk(in_clk), .rst(g_rst), .en(g_en), .up_dn(g_up), .load(g_load),
    .load_val(g_lv), .q(g_q), .tick(g_tick), .carry(g_carry)
`ifdef CNT_MOD_BCD_EN
    , .bcd_tens(g_bt), .bcd_ones(g_bo)
`endif
  );

  // ---------------- cascade: seconds (default) -> minutes (PRESCALE=1) ----------------
  logic       c_rst, c_en;
  logic [6:0] lo_q, hi_q;
  logic       lo_tick, lo_carry, hi_tick, hi_carry;
`ifdef CNT_MOD_BCD_EN
  logic [3:0] lo_bt, lo_bo, hi_bt, hi_bo;
`endif

  cnt_mod_prescaled u_lo (
    .in_clk(in_clk), .rst(c_rst), .en(c_en), .up_dn(1'b1), .load(1'b0),
    .load_val(7'd0), .q(lo_q), .tick(lo_tick), .carry(lo_carry)
`ifdef CNT_MOD_BCD_EN
    , .bcd_tens(lo_bt), .bcd_ones(lo_bo)
`endif
  );

  cnt_mod_prescaled #(.PRESCALE(1), .PS_WIDTH(1), .MODULUS(60), .WIDTH(7)) u_hi (
    .in_clk(in_clk), .rst(c_rst), .en(lo_carry), .up_dn(1'b1), .load(1'b0),
    .load_val(7'd0), .q(hi_q), .tick(hi_tick), .carry(hi_carry)
`ifdef CNT_MOD_BCD_EN
    , .bcd_tens(hi_bt), .bcd_ones(hi_bo)
`endif
  );

  // ---------------- behavioural model of the small instance ----------------
  // Counts enabled cycles since the last reset/load and applies modular arithmetic
  // once every SP of them; wrap is detected by the unreduced result leaving 0..SM-1.
  int m_phase, m_q, m_nxt;
  bit m_tick, m_carry;

  always @(posedge in_clk) begin
    if (s_rst) begin
      m_phase = 0; m_q = 0; m_tick = 0; m_carry = 0;
    end else if (s_load) begin
      m_phase = 0; m_tick = 0; m_carry = 0;
      m_q = (int'(s_lv) >= SM) ? SM - 1 : int'(s_lv);
    end else if (!s_en) begin
      m_tick = 0; m_carry = 0;
    end else begin
      m_phase = m_phase + 1;
      m_tick = 0; m_carry = 0;
      if (m_phase == SP) begin
        m_phase = 0;
        m_tick  = 1;
        m_nxt   = s_up ? m_q + 1 : m_q - 1;
        m_carry = (m_nxt < 0) || (m_nxt >= SM);
        m_q     = (m_nxt + SM) % SM;
      end
    end
  end

  bit chk_en;
  always @(negedge in_clk) begin
    if (chk_en) begin
      chk("model_q", s_q, m_q);
      chk("model_tick", s_tick, m_tick);
      chk("model_carry", s_carry, m_carry);
`ifdef CNT_MOD_BCD_EN
      chk("model_bcd_tens", s_bt, m_q / 10);
      chk("model_bcd_ones", s_bo, m_q % 10);
`endif
    end
  end

  int s_ticks, s_carries, g_carries, hi_ticks;
  initial begin
    s_ticks = 0; s_carries = 0; g_carries = 0; hi_ticks = 0;
  end
  always @(negedge in_clk) begin
    if (s_tick === 1'b1)  s_ticks++;
    if (s_carry === 1'b1) s_carries++;
    if (g_carry === 1'b1) g_carries++;
    if (hi_tick === 1'b1) hi_ticks++;
  end

  task automatic wait_s_tick(input string name, input int limit, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (s_tick !== 1'b1 && n < limit);
    chk(name, s_tick, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int t0, c0, h0, n, e;

  initial begin
    n_chk = 0; n_fail = 0; chk_en = 0;
    s_rst = 1; s_en = 1; s_up = 1; s_load = 0; s_lv = '0;
    g_rst = 1; g_en = 0; g_up = 1; g_load = 0; g_lv = '0;
    c_rst = 1; c_en = 0;

    // Reset with en=1 for two cycles.
    cyc(2);
    chk("rst_q", s_q, 0);
    chk("rst_tick", s_tick, 0);
    chk("rst_carry", s_carry, 0);
    chk_en = 1;

    // Hold with en=0.
    s_rst = 0; s_en = 0;
    t0 = s_ticks;
    cyc(20);
    chk("hold_q", s_q, 0);
    chk("hold_ticks", s_ticks - t0, 0);

    // Up count and wrap.
    t0 = s_ticks; c0 = s_carries;
    s_en = 1; s_up = 1;
    cyc(4);
    chk("up_first_q", s_q, 1);
    chk("up_first_tick", s_tick, 1);
    chk("up_first_carry", s_carry, 0);
    cyc(36);
    chk("up_wrap_q", s_q, 0);
    chk("up_wrap_tick", s_tick, 1);
    chk("up_wrap_carry", s_carry, 1);
    chk("up_ticks", s_ticks - t0, 10);
    chk("up_carries", s_carries - c0, 1);

    // Down count and borrow from a loaded 0.
    s_lv = 4'd0; s_load = 1;
    cyc(1);
    chk("load0_q", s_q, 0);
    chk("load0_tick", s_tick, 0);
    s_load = 0; s_up = 0;
    wait_s_tick("dn1_seen", 8, n);
    chk("dn1_latency", n, 4);
    chk("dn1_q", s_q, 9);
    chk("dn1_carry", s_carry, 1);
    wait_s_tick("dn2_seen", 8, n);
    chk("dn2_latency", n, 4);
    chk("dn2_q", s_q, 8);
    chk("dn2_carry", s_carry, 0);

    // Load at ps=3 with an out-of-range value: clamp, no pulse, phase restarts.
    cyc(3);
    s_lv = 4'd15; s_load = 1;
    cyc(1);
    chk("clamp_q", s_q, 9);
    chk("clamp_tick", s_tick, 0);
    chk("clamp_carry", s_carry, 0);
    s_load = 0;
    wait_s_tick("clamp_step_seen", 8, n);
    chk("clamp_step_latency", n, 4);
    chk("clamp_step_q", s_q, 8);

    // Reset wins over load.
    s_rst = 1; s_load = 1; s_lv = 4'd5;
    cyc(1);
    chk("rst_over_load_q", s_q, 0);
    s_rst = 0; s_load = 0;

    // Mixed directed pattern: enable gaps, direction flips mid-prescale, sporadic loads.
    for (int i = 0; i < 200; i++) begin
      s_en   = (i % 7) != 3;
      s_up   = ((i / 23) % 2) == 0;
      s_load = (i % 61) == 60;
      s_lv   = 4'(i % 16);
      cyc(1);
    end
    s_load = 0;
    chk_en = 0;

    // MODULUS=60 instance: reset, clamp, load 47 then 13 up steps.
    cyc(1);
    g_rst = 0;
    chk("m60_rst_q", g_q, 0);
    g_lv = 7'd99; g_load = 1;
    cyc(1);
    chk("m60_clamp_q", g_q, 59);
`ifdef CNT_MOD_BCD_EN
    chk("m60_clamp_tens", g_bt, 5);
    chk("m60_clamp_ones", g_bo, 9);
`endif
    g_lv = 7'd47;
    cyc(1);
    chk("m60_load_q", g_q, 47);
`ifdef CNT_MOD_BCD_EN
    chk("m60_load_tens", g_bt, 4);
    chk("m60_load_ones", g_bo, 7);
`endif
    g_load = 0; g_en = 1; g_up = 1;
    c0 = g_carries;
    for (int k = 1; k <= 13; k++) begin
      cyc(3);
      e = (47 + k) % 60;
      chk("m60_step_tick", g_tick, 1);
      chk("m60_step_q", g_q, e);
      chk("m60_step_carry", g_carry, (k == 13) ? 1 : 0);
`ifdef CNT_MOD_BCD_EN
      chk("m60_step_tens", g_bt, e / 10);
      chk("m60_step_ones", g_bo, e % 10);
`endif
    end
    chk("m60_carries", g_carries - c0, 1);
    g_en = 0;

    // Cascade: one minute of seconds, then a second minute with a 100-cycle pause.
    cyc(1);
    c_rst = 0; c_en = 1;
    h0 = hi_ticks;
    cyc(36000);
    chk("casc_lo_carry", lo_carry, 1);
    chk("casc_lo_q", lo_q, 0);
    chk("casc_hi_q_before", hi_q, 0);
    cyc(1);
    chk("casc_hi_q", hi_q, 1);
    chk("casc_hi_tick", hi_tick, 1);
    chk("casc_lo_q_after", lo_q, 0);
    chk("casc_hi_ticks", hi_ticks - h0, 1);
    cyc(5000);
    c_en = 0;
    cyc(100);
    c_en = 1;
    cyc(30900);
    chk("casc_pause_not_early", hi_q, 1);
    cyc(99);
    chk("casc_pause_lo_carry", lo_carry, 1);
    chk("casc_pause_hi_before", hi_q, 1);
    cyc(1);
    chk("casc_pause_hi_q", hi_q, 2);
    chk("casc_pause_hi_ticks", hi_ticks - h0, 2);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/cnt_mod_prescaled.md
Name: cnt_mod_prescaled

Overview:
- Parametrised, prescaled modulo counter for the digital clock datapath; successor to the fixed seconds/minutes counters.
- One internal prescaler divides the enabled clock by PRESCALE; each prescaler terminal count steps the main counter modulo MODULUS, up or down.
- Outputs registered tick and carry pulses so instances cascade (seconds -> minutes -> hours), plus a synchronous load for time-setting.

Parameters:
- PRESCALE, 600, input cycles per counter step; legal range >= 1.
- PS_WIDTH, 10, prescaler register width; must satisfy 2^PS_WIDTH >= PRESCALE.
- MODULUS, 60, counter wraps after MODULUS-1; legal range 2..100.
- WIDTH, 7, counter width; must satisfy 2^WIDTH >= MODULUS.

Ports:
- in_clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable; prescaler and counter hold when low.
- up_dn  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value written on load.
- q  output  WIDTH  current count, 0..MODULUS-1.
- tick  output  1  one-cycle pulse on every counter step.
- carry  output  1  one-cycle pulse on wrap: up MODULUS-1->0, down 0->MODULUS-1.

Behaviour:
- All state updates on posedge in_clk. Priority order: rst > load > en.
- Reset, sampled at the clock edge only: ps=0, q=0, tick=0, carry=0. Reset mid-count discards the prescaler phase.
- Load, any en value: q=load_val, or MODULUS-1 if load_val >= MODULUS (clamped). ps=0; tick=0; carry=0. No pulse is generated by a load.
- en=0, no load: ps and q hold; tick=0; carry=0.
- en=1, ps != PRESCALE-1: ps=ps+1; tick=0; carry=0.
- en=1, ps == PRESCALE-1, then ps=0 and tick=1 for one cycle.
  - Up: q=q+1, or q=0 with carry=1 if q==MODULUS-1.
  - Down: q=q-1, or q=MODULUS-1 with carry=1 if q==0.
- tick and carry are registered. They are high in the same cycle the new q value is visible, so zero-latency relative to q.
- PRESCALE=1: ps stays 0; q steps every enabled cycle and tick stays high continuously while en=1.
- up_dn is sampled only at the step edge; changing it mid-prescale affects only the next step.
- q never leaves 0..MODULUS-1 under any input sequence.
- Cascading: the downstream instance has en tied to upstream carry and PRESCALE=1.
- No combinational path from any input to any output.

Optional Feature:
- Macro: CNT_MOD_BCD_EN.
- Defined: adds outputs bcd_tens[3:0] and bcd_ones[3:0], registered, equal to q/10 and q%10, and updated in the same cycle as q (no extra latency). Reset and load update them consistently with q. Implemented as a parallel BCD counter pair, not a divider.
- Undefined: the ports and logic are absent; behaviour of all other outputs is identical.

Test Plan:
- Reset/hold (PRESCALE=4, MODULUS=10): assert rst 2 cycles with en=1 -> q=0, tick=0, carry=0. Deassert with en=0 for 20 cycles -> q stays 0, no pulses.
- Up count/wrap: en=1, up_dn=1, run 40 cycles -> tick every 4th cycle. q steps 0..9 then 0; carry=1 for exactly one cycle when q returns to 0, coincident with tick.
- Down count/borrow: load_val=0, pulse load, then up_dn=0, en=1 -> first step gives q=9 with carry=1, next step gives q=8 with carry=0.
- Load priority/clamp: load=1 with load_val=15 while en=1 at ps=3 -> q=9, no tick/carry that cycle, and the next step occurs 4 cycles later. Then rst and load together -> q=0.
- Cascade (default params, PRESCALE=600/MODULUS=60 feeding PRESCALE=1/MODULUS=60): 36000 cycles -> upper q=1, lower q=0, upper steps exactly once. Deasserting en for 100 cycles mid-run delays the upper step by 100 cycles.
- CNT_MOD_BCD_EN defined: load 47 then step up 13 times -> q, bcd_tens and bcd_ones track every step. The final value is q=0 with bcd_tens=0 and bcd_ones=0 (47+13 = 60 wraps to 0), carry pulses once.
